// File: rtl/mult8x8_pkg.sv
// Shared constants for the nibble-serial 8x8 multiplier controller:
// state codes, shifter codes and operand-nibble select codes.
package mult8x8_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_CALC = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] SH_0 = 2'd0;
    localparam logic [1:0] SH_4 = 2'd1;
    localparam logic [1:0] SH_8 = 2'd2;

    localparam logic [1:0] SEL_ALBL = 2'd0;
    localparam logic [1:0] SEL_ALBH = 2'd1;
    localparam logic [1:0] SEL_AHBL = 2'd2;
    localparam logic [1:0] SEL_AHBH = 2'd3;

    // Cross terms (lo*hi, hi*lo) both carry weight 2^4; hi*hi carries 2^8.
    function automatic logic [1:0] shift_for_count(input logic [1:0] c);
        case (c)
            2'd0:    return SH_0;
            2'd1:    return SH_4;
            2'd2:    return SH_4;
            default: return SH_8;
        endcase
    endfunction

    function automatic logic [1:0] sel_for_count(input logic [1:0] c);
        case (c)
            2'd0:    return SEL_ALBL;
            2'd1:    return SEL_ALBH;
            2'd2:    return SEL_AHBL;
            default: return SEL_AHBH;
        endcase
    endfunction

endpackage

// File: rtl/mult8x8_ctrl_if.sv
// Start/done handshake and datapath control bundle of the multiplier controller.
// start is a level request; each rising edge launches one multiply; done pulses one cycle.
interface mult8x8_ctrl_if;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_cntrl;
    logic       clk_ena;
    logic       sclr_n;
    logic       done;
    logic       err;
    logic [2:0] state_out;

    modport master (
        output start,
        input  input_sel, shift_cntrl, clk_ena, sclr_n, done, err, state_out
    );

    modport slave (
        input  start,
        output input_sel, shift_cntrl, clk_ena, sclr_n, done, err, state_out
    );
endinterface

// File: rtl/mult8x8_ctrl_dec.sv
// Moore output decoder: maps {state, count} onto the datapath controls.
// Illegal state codes decode as idle outputs while the FSM recovers.
module mult8x8_ctrl_dec
    import mult8x8_pkg::*;
(
    input  state_t     state,
    input  logic [1:0] count,
    output logic [1:0] input_sel,
    output logic [1:0] shift_cntrl,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       done,
    output logic       err,
    output logic [2:0] state_out
);

    always_comb begin
        input_sel   = SEL_ALBL;
        shift_cntrl = SH_0;
        clk_ena     = 1'b0;
        sclr_n      = 1'b1;
        done        = 1'b0;
        err         = 1'b0;
        state_out   = state;
        case (state)
            S_CLR: begin
                clk_ena = 1'b1;
                sclr_n  = 1'b0;
            end
            S_CALC: begin
                input_sel   = sel_for_count(count);
                shift_cntrl = shift_for_count(count);
                clk_ena     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mult8x8_ctrl.sv
// Sequencing FSM for the nibble-serial 8x8 multiplier: clear, four accumulate
// cycles, one-cycle done; a start edge while busy aborts into ERR.
module mult8x8_ctrl
    import mult8x8_pkg::*;
(
    input  logic          clk,
    input  logic          reset_a,
    mult8x8_ctrl_if.slave bus
);

    state_t     state;
    logic [1:0] count;
    logic       start_q;
    logic       start_edge;

    assign start_edge = bus.start & ~start_q;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state   <= S_IDLE;
            count   <= 2'd0;
            start_q <= 1'b0;
        end else begin
            start_q <= bus.start;
            case (state)
                S_IDLE: if (start_edge) state <= S_CLR;
                S_CLR: begin
                    count <= 2'd0;
                    state <= start_edge ? S_ERR : S_CALC;
                end
                S_CALC: begin
                    if (start_edge) begin
                        state <= S_ERR;
                        count <= 2'd0;
                    end else if (count == 2'd3) begin
                        state <= S_DONE;
                        count <= 2'd0;
                    end else begin
                        count <= count + 2'd1;
                    end
                end
                S_DONE: state <= start_edge ? S_CLR : S_IDLE;
                S_ERR:  if (start_edge) state <= S_CLR;
                default: begin
                    state <= S_IDLE;
                    count <= 2'd0;
                end
            endcase
        end
    end

    mult8x8_ctrl_dec u_dec (
        .state       (state),
        .count       (count),
        .input_sel   (bus.input_sel),
        .shift_cntrl (bus.shift_cntrl),
        .clk_ena     (bus.clk_ena),
        .sclr_n      (bus.sclr_n),
        .done        (bus.done),
        .err         (bus.err),
        .state_out   (bus.state_out)
    );

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Bench for mult8x8_ctrl: a behavioural 4x4/shift/accumulate datapath driven by the
// controller outputs; products are checked against hand-computed values at each done.
module tb_mult8x8_ctrl;

    logic clk;
    logic reset_a;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [15:0] acc;

    logic [15:0] exp_q[$];
    int vectors;
    int miscompares;
    int done_cnt;

    mult8x8_ctrl_if bus ();

    mult8x8_ctrl dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // datapath model: nibble multiply, shift, accumulate with synchronous clear
    always @(posedge clk) begin : datapath
        logic [3:0]  a_n;
        logic [3:0]  b_n;
        logic [15:0] pp;
        a_n = bus.input_sel[1] ? op_a[7:4] : op_a[3:0];
        b_n = bus.input_sel[0] ? op_b[7:4] : op_b[3:0];
        pp  = 16'(a_n) * 16'(b_n);
        if (bus.shift_cntrl == 2'd1)      pp = pp << 4;
        else if (bus.shift_cntrl == 2'd2) pp = pp << 8;
        if (bus.clk_ena) begin
            if (!bus.sclr_n) acc <= 16'h0000;
            else             acc <= acc + pp;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset_a && bus.done) begin
            done_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got product %h, none expected", acc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (acc !== e) begin
                    miscompares++;
                    $display("FAIL product: got %h expected %h", acc, e);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"},   16'(bus.state_out),   16'd0);
        chk({tag, "_sel"},     16'(bus.input_sel),   16'd0);
        chk({tag, "_shift"},   16'(bus.shift_cntrl), 16'd0);
        chk({tag, "_clk_ena"}, 16'(bus.clk_ena),     16'd0);
        chk({tag, "_sclr_n"},  16'(bus.sclr_n),      16'd1);
        chk({tag, "_done"},    16'(bus.done),        16'd0);
        chk({tag, "_err"},     16'(bus.err),         16'd0);
    endtask

    initial begin
        logic [1:0] sh_tab [4];
        int guard;
        int d0;
        sh_tab[0] = 2'd0; sh_tab[1] = 2'd1; sh_tab[2] = 2'd1; sh_tab[3] = 2'd2;
        vectors = 0; miscompares = 0; done_cnt = 0;
        acc = 16'h0000;
        reset_a = 1'b1;
        bus.start = 1'b0;
        op_a = 8'h00; op_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset_a = 1'b0;
        tick();

        // single multiply with full schedule check
        op_a = 8'hF4; op_b = 8'h3B;
        exp_q.push_back(16'h383C);
        pulse_start();
        chk("clr_state",  16'(bus.state_out), 16'd1);
        chk("clr_sclr_n", 16'(bus.sclr_n),    16'd0);
        chk("clr_ena",    16'(bus.clk_ena),   16'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("calc_state", 16'(bus.state_out),   16'd2);
            chk("calc_sel",   16'(bus.input_sel),   16'(i));
            chk("calc_shift", 16'(bus.shift_cntrl), 16'(sh_tab[i]));
            chk("calc_ena",   16'(bus.clk_ena),     16'd1);
        end
        tick();
        chk("done_pulse", 16'(bus.done),      16'd1);
        chk("done_state", 16'(bus.state_out), 16'd3);
        chk("done_ena",   16'(bus.clk_ena),   16'd0);
        tick();
        chk("back_idle",  16'(bus.state_out), 16'd0);
        chk("done_clear", 16'(bus.done),      16'd0);

        // back-to-back
        op_a = 8'hFF; op_b = 8'hFF;
        exp_q.push_back(16'hFE01);
        exp_q.push_back(16'hFE01);
        pulse_start();
        repeat (5) tick();
        chk("b2b_done1", 16'(bus.done), 16'd1);
        pulse_start();
        chk("b2b_clr", 16'(bus.state_out), 16'd1);
        repeat (5) tick();
        chk("b2b_done2", 16'(bus.done), 16'd1);
        tick();

        // protocol error during CALC count=1, then restart
        op_a = 8'h33; op_b = 8'h44;
        pulse_start();
        tick();
        tick();
        chk("err_pre_sel", 16'(bus.input_sel), 16'd1);
        pulse_start();
        chk("err_state", 16'(bus.state_out), 16'd4);
        chk("err_flag",  16'(bus.err),       16'd1);
        chk("err_ena",   16'(bus.clk_ena),   16'd0);
        tick();
        chk("err_hold",  16'(bus.err),       16'd1);
        op_a = 8'h05; op_b = 8'h07;
        exp_q.push_back(16'h0023);
        pulse_start();
        chk("err_restart", 16'(bus.state_out), 16'd1);
        repeat (5) tick();
        chk("restart_done", 16'(bus.done), 16'd1);
        tick();

        // held start gives exactly one product
        op_a = 8'h12; op_b = 8'h34;
        exp_q.push_back(16'h03A8);
        d0 = done_cnt;
        bus.start = 1'b1;
        repeat (20) tick();
        bus.start = 1'b0;
        tick();
        chk("held_done_count", 16'(done_cnt - d0), 16'd1);

        // asynchronous reset during CALC count=2
        op_a = 8'hAB; op_b = 8'hCD;
        pulse_start();
        repeat (3) tick();
        chk("rst_pre_sel", 16'(bus.input_sel), 16'd2);
        #2 reset_a = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        #2 reset_a = 1'b0;
        tick();
        op_a = 8'h10; op_b = 8'h10;
        exp_q.push_back(16'h0100);
        pulse_start();
        repeat (5) tick();
        chk("post_rst_done", 16'(bus.done), 16'd1);
        tick();

        // drain scoreboard
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("pending_products", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
